// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the flags record
// used by the result stage.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    localparam int FLG_S = 3;
    localparam int FLG_C = 2;
    localparam int FLG_P = 1;
    localparam int FLG_Z = 0;

    // Field order matches the FLG_* bit indices when the struct is packed.
    typedef struct packed {
        logic s;
        logic c;
        logic p;
        logic z;
    } alu_flags_t;

    // Width of one stored entry: {result[15:0], opcode, flags}.
    localparam int ENTRY_W = 16 + 3 + 4;

endpackage

// File: rtl/alu_result_stage_fifo.sv
// Synchronous FIFO with occupancy count; the head is read straight from storage
// and the last popped word is held while the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic [WIDTH-1:0] last_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    // A full FIFO refuses the write even if a pop frees a slot this cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign rdata = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            last_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind the 16-bit ALU: queues results with opcode and
// flags, and tracks sticky carry/zero status plus a count of accepted pushes.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:0]      in_result,
    input  logic [2:0]       in_opcode,
    input  logic             in_s,
    input  logic             in_c,
    input  logic             in_p,
    input  logic             in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [2:0]       out_opcode,
    output logic [3:0]       out_flags,
    output logic             sticky_c,
    output logic             sticky_z,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic [LW-1:0]    level
);

    // The ALU may report carry either on in_c or on result bit 16.
    function automatic alu_flags_t merge_flags(input logic [16:0] r, input logic s,
                                               input logic c, input logic p,
                                               input logic z);
        alu_flags_t f;
        f.s = s;
        f.c = c | r[16];
        f.p = p;
        f.z = z;
        return f;
    endfunction

    alu_flags_t           flags_in;
    logic [ENTRY_W-1:0]   wdata;
    logic [ENTRY_W-1:0]   rdata;
    logic                 full;
    logic                 empty;
    logic                 push_acc;

    assign flags_in  = merge_flags(in_result, in_s, in_c, in_p, in_z);
    assign wdata     = {in_result[15:0], in_opcode, flags_in};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push_acc  = in_valid && !full;
    assign {out_result, out_opcode, out_flags} = rdata;

    sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (in_valid),
        .pop  (out_ready),
        .wdata(wdata),
        .rdata(rdata),
        .full (full),
        .empty(empty),
        .level(level)
    );

    // A push that sets a sticky bit takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= '0;
            sticky_c <= 1'b0;
            sticky_z <= 1'b0;
        end else begin
            if (push_acc) begin
                op_count <= op_count + CNT_W'(1);
            end
            if (push_acc && flags_in.c) begin
                sticky_c <= 1'b1;
            end else if (clr_sticky) begin
                sticky_c <= 1'b0;
            end
            if (push_acc && flags_in.z) begin
                sticky_z <= 1'b1;
            end else if (clr_sticky) begin
                sticky_z <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed pushes queue their expected
// head words, a negedge monitor checks every pop against the queue.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [16:0] in_result = '0;
    logic [2:0]  in_opcode = '0;
    logic        in_s = 1'b0, in_c = 1'b0, in_p = 1'b0, in_z = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic [2:0]  out_opcode;
    logic [3:0]  out_flags;
    logic        sticky_c, sticky_z;
    logic        clr_sticky = 1'b0;
    logic [15:0] op_count;
    logic [2:0]  level;

    // Narrow-counter instance to reach the op_count wrap quickly.
    logic        w_in_valid = 1'b0;
    logic        w_in_ready, w_out_valid, w_sticky_c, w_sticky_z;
    logic [15:0] w_out_result;
    logic [2:0]  w_out_opcode;
    logic [3:0]  w_out_flags;
    logic [3:0]  w_op_count;
    logic [1:0]  w_level;

    int npass = 0;
    int ntotal = 0;
    logic [22:0] exp_q[$];
    logic [22:0] mon_e;
    logic        acc;

    always #5 clk = ~clk;

    alu_result_stage #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_opcode(in_opcode),
        .in_s(in_s), .in_c(in_c), .in_p(in_p), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_opcode(out_opcode), .out_flags(out_flags),
        .sticky_c(sticky_c), .sticky_z(sticky_z), .clr_sticky(clr_sticky),
        .op_count(op_count), .level(level)
    );

    alu_result_stage #(.DEPTH(2), .CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_result(17'h00001), .in_opcode(3'd0),
        .in_s(1'b0), .in_c(1'b0), .in_p(1'b0), .in_z(1'b0),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_result(w_out_result),
        .out_opcode(w_out_opcode), .out_flags(w_out_flags),
        .sticky_c(w_sticky_c), .sticky_z(w_sticky_z), .clr_sticky(1'b0),
        .op_count(w_op_count), .level(w_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("mon_unexpected_pop", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_head", 32'({out_result, out_opcode, out_flags}), 32'(mon_e));
            end
        end
    end

    // f/ef are {s,c,p,z}: driven flags and hand-computed stored flags.
    task automatic push(input logic [16:0] r, input logic [2:0] op, input logic [3:0] f,
                        input logic [3:0] ef, output logic a);
        in_valid  = 1'b1;
        in_result = r;
        in_opcode = op;
        {in_s, in_c, in_p, in_z} = f;
        @(negedge clk);
        a = in_ready;
        @(posedge clk);
        #1;
        if (a) exp_q.push_back({r[15:0], op, ef});
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!out_valid) break;
        end
        chk({name, "_timeout"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic clr_only();
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] t2_res [5] = '{17'h01111, 17'h02222, 17'h13333, 17'h04444, 17'h05555};
        logic [3:0]  t2_f   [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1111};
        logic [3:0]  t2_ef  [5] = '{4'b1000, 4'b0100, 4'b0110, 4'b0001, 4'b1111};

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_sticky", 32'({sticky_c, sticky_z}), 32'd0);
        chk("rst_head", 32'({out_result, out_opcode, out_flags}), 32'd0);

        // 1: carry carried only on result bit 16, zero flag set
        in_valid = 1'b1; in_result = 17'h10000; in_opcode = 3'd0;
        {in_s, in_c, in_p, in_z} = 4'b0001;
        @(negedge clk);
        chk("t1_no_bypass", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        exp_q.push_back({16'h0000, 3'd0, 4'b0101});
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_result", 32'(out_result), 32'h0000);
        chk("t1_out_flags", 32'(out_flags), 32'h5);
        chk("t1_sticky", 32'({sticky_c, sticky_z}), 32'h3);
        chk("t1_level", 32'(level), 32'd1);
        drain("t1_drain");

        // 2: fill to full, fifth push refused even with a pop in the same cycle
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(t2_res[i], 3'(i + 1), t2_f[i], t2_ef[i], acc);
            chk("t2_accept", 32'(acc), 32'd1);
        end
        chk("t2_in_ready_full", 32'(in_ready), 32'd0);
        chk("t2_level_full", 32'(level), 32'd4);
        chk("t2_op_count", 32'(op_count), 32'd4);
        out_ready = 1'b1;
        push(t2_res[4], 3'd5, t2_f[4], t2_ef[4], acc);
        out_ready = 1'b0;
        chk("t2_fifth_refused", 32'(acc), 32'd0);
        chk("t2_level_after_pop", 32'(level), 32'd3);
        chk("t2_op_count_after", 32'(op_count), 32'd4);
        drain("t2_drain");
        chk("t2_hold_last", 32'({out_result, out_opcode, out_flags}), 32'({16'h4444, 3'd4, 4'b0001}));

        // 3: steady push+pop at level 2
        for (int i = 0; i < 2; i++) begin
            push(17'(16'hA000 + 16'(i)), 3'(i), 4'b0000, 4'b0000, acc);
        end
        chk("t3_level_start", 32'(level), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push(17'(16'hB000 + 16'(i)), 3'(i % 8), 4'b0010, 4'b0010, acc);
            chk("t3_level", 32'(level), 32'd2);
        end
        out_ready = 1'b0;
        chk("t3_op_count", 32'(op_count), 32'd26);
        drain("t3_drain");

        // 4: sticky set beats clear
        chk("t4_pre_sticky", 32'({sticky_c, sticky_z}), 32'h3);
        clr_only();
        chk("t4_cleared", 32'({sticky_c, sticky_z}), 32'h0);
        clr_sticky = 1'b1;
        push(17'h00010, 3'd1, 4'b0101, 4'b0101, acc);
        clr_sticky = 1'b0;
        chk("t4_set_wins", 32'({sticky_c, sticky_z}), 32'h3);
        clr_only();
        chk("t4_clear_again", 32'({sticky_c, sticky_z}), 32'h0);
        clr_sticky = 1'b1;
        push(17'h10001, 3'd0, 4'b0000, 4'b0100, acc);
        clr_sticky = 1'b0;
        chk("t4_carry_bit16", 32'({sticky_c, sticky_z}), 32'h2);
        drain("t4_drain");

        // 6: asynchronous reset with entries in flight
        for (int i = 0; i < 3; i++) begin
            push(17'(16'hC000 + 16'(i)), 3'd2, 4'b0000, 4'b0000, acc);
        end
        chk("t6_level3", 32'(level), 32'd3);
        chk("t6_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(out_valid), 32'd0);
        chk("t6_async_level", 32'(level), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6_op_count", 32'(op_count), 32'd0);
        push(17'h07777, 3'd7, 4'b1000, 4'b1000, acc);
        chk("t6_first_valid", 32'(out_valid), 32'd1);
        chk("t6_first_result", 32'(out_result), 32'h7777);
        drain("t6_drain");

        // 5: op_count wrap on the 4-bit counter instance
        w_in_valid = 1'b1;
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        chk("t5_count_max", 32'(w_op_count), 32'hF);
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        chk("t5_wrap", 32'(w_op_count), 32'h0);

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
